// File: rtl/mtl_lcd_pkg.sv
// Shared timing defaults, pixel type and window-compare helper for the MTL LCD transmitter.
package mtl_lcd_pkg;

  localparam int H_TOTAL_D     = 1056;
  localparam int H_SYNC_D      = 30;
  localparam int H_ACT_START_D = 50;
  localparam int H_ACT_D       = 800;
  localparam int V_TOTAL_D     = 525;
  localparam int V_SYNC_D      = 13;
  localparam int V_ACT_START_D = 23;
  localparam int V_ACT_D       = 480;

  localparam logic [23:0] UNDERFLOW_RGB = 24'hFF00FF;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;

  // True when start <= cnt < start+len; vcnt callers zero-extend to 11 bits.
  function automatic logic in_window(input logic [10:0] cnt, input int start, input int len);
    return (32'(cnt) >= 32'(start)) && (32'(cnt) < 32'(start + len));
  endfunction

endpackage

// File: rtl/mtl_lcd_tx_if.sv
// Show-ahead pixel FIFO link between the upstream scaler (master) and the LCD transmitter (slave).
interface mtl_lcd_tx_if;
  logic [23:0] i_pix_data;
  logic        i_pix_empty;
  logic        o_pix_rd;

  modport master (output i_pix_data, output i_pix_empty, input o_pix_rd);
  modport slave  (input i_pix_data, input i_pix_empty, output o_pix_rd);
endinterface

// File: rtl/mtl_timing_cnt.sv
// 800x480 panel raster counters plus the combinational flags decoded from them.
module mtl_timing_cnt
  import mtl_lcd_pkg::*;
#(
  parameter int H_TOTAL     = H_TOTAL_D,
  parameter int H_SYNC      = H_SYNC_D,
  parameter int H_ACT_START = H_ACT_START_D,
  parameter int H_ACT       = H_ACT_D,
  parameter int V_TOTAL     = V_TOTAL_D,
  parameter int V_SYNC      = V_SYNC_D,
  parameter int V_ACT_START = V_ACT_START_D,
  parameter int V_ACT       = V_ACT_D
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  output logic [10:0] o_hcnt,
  output logic [9:0]  o_vcnt,
  output logic        o_act,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_frame_start,
  output logic        o_line_req,
  output logic        o_vblank
);

  logic [10:0] r_hcnt;
  logic [9:0]  r_vcnt;
  logic        w_h_last;
  logic        w_v_last;
  logic        w_v_act;

  assign w_h_last = (r_hcnt == 11'(H_TOTAL - 1));
  assign w_v_last = (r_vcnt == 10'(V_TOTAL - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; reset is synchronous, so it sits inside the clocked branch.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (w_h_last) begin
      r_hcnt <= '0;
      r_vcnt <= w_v_last ? '0 : r_vcnt + 10'd1;
    end else begin
      r_hcnt <= r_hcnt + 11'd1;
    end
  end

  assign w_v_act       = in_window({1'b0, r_vcnt}, V_ACT_START, V_ACT);
  assign o_act         = in_window(r_hcnt, H_ACT_START, H_ACT) && w_v_act;
  assign o_hsync       = (32'(r_hcnt) < 32'(H_SYNC));
  assign o_vsync       = (32'(r_vcnt) < 32'(V_SYNC));
  assign o_frame_start = (r_hcnt == '0) && (r_vcnt == '0);
  // Request goes out one line early so the scaler can prefill the FIFO.
  assign o_line_req    = (r_hcnt == '0) && in_window({1'b0, r_vcnt}, V_ACT_START - 1, V_ACT);
  assign o_vblank      = !w_v_act;
  assign o_hcnt        = r_hcnt;
  assign o_vcnt        = r_vcnt;

endmodule

// File: rtl/mtl_lcd_tx.sv
// MTL LCD transmitter: FIFO pop, RGB select and the registered panel pins.
module mtl_lcd_tx
  import mtl_lcd_pkg::*;
#(
  parameter int H_TOTAL     = H_TOTAL_D,
  parameter int H_SYNC      = H_SYNC_D,
  parameter int H_ACT_START = H_ACT_START_D,
  parameter int H_ACT       = H_ACT_D,
  parameter int V_TOTAL     = V_TOTAL_D,
  parameter int V_SYNC      = V_SYNC_D,
  parameter int V_ACT_START = V_ACT_START_D,
  parameter int V_ACT       = V_ACT_D
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  mtl_lcd_tx_if.slave  fifo,
  output logic         o_hsd,
  output logic         o_vsd,
  output logic         o_de,
  output logic [7:0]   o_r,
  output logic [7:0]   o_g,
  output logic [7:0]   o_b,
  output logic         o_frame_start,
  output logic         o_line_req,
  output logic         o_vblank,
  output logic         o_underflow
);

  logic [10:0] w_hcnt;
  logic [9:0]  w_vcnt;
  logic        w_act;
  logic        w_hsync;
  logic        w_vsync;
  logic        w_frame_start;
  logic        w_line_req;
  logic        w_vblank;
  rgb24_t      w_pix;

  logic   r_hsd;
  logic   r_vsd;
  logic   r_de;
  rgb24_t r_rgb;
  logic   r_frame_start;
  logic   r_line_req;
  logic   r_vblank;
  logic   r_underflow;

  mtl_timing_cnt #(
    .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC), .H_ACT_START(H_ACT_START), .H_ACT(H_ACT),
    .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC), .V_ACT_START(V_ACT_START), .V_ACT(V_ACT)
  ) u_timing (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_en         (i_en),
    .o_hcnt       (w_hcnt),
    .o_vcnt       (w_vcnt),
    .o_act        (w_act),
    .o_hsync      (w_hsync),
    .o_vsync      (w_vsync),
    .o_frame_start(w_frame_start),
    .o_line_req   (w_line_req),
    .o_vblank     (w_vblank)
  );

  assign fifo.o_pix_rd = i_en & w_act & ~fifo.i_pix_empty;

  // NOTE: the default assignment first keeps this block purely combinational (no latch).
  // FIFO data is only selected when non-empty, so an X head word never reaches the pins.
  always_comb begin
    w_pix = '0;
    if (w_act) w_pix = fifo.i_pix_empty ? rgb24_t'(UNDERFLOW_RGB) : rgb24_t'(fifo.i_pix_data);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hsd         <= 1'b1;
      r_vsd         <= 1'b1;
      r_de          <= 1'b0;
      r_rgb         <= '0;
      r_frame_start <= 1'b0;
      r_line_req    <= 1'b0;
      r_vblank      <= 1'b1;
      r_underflow   <= 1'b0;
    end else if (!i_en) begin
      r_hsd         <= 1'b1;
      r_vsd         <= 1'b1;
      r_de          <= 1'b0;
      r_rgb         <= '0;
      r_frame_start <= 1'b0;
      r_line_req    <= 1'b0;
      r_vblank      <= 1'b1;
    end else begin
      r_hsd         <= ~w_hsync;
      r_vsd         <= ~w_vsync;
      r_de          <= w_act;
      r_rgb         <= w_pix;
      r_frame_start <= w_frame_start;
      r_line_req    <= w_line_req;
      r_vblank      <= w_vblank;
      if (w_act && fifo.i_pix_empty) r_underflow <= 1'b1;
    end
  end

  assign o_hsd         = r_hsd;
  assign o_vsd         = r_vsd;
  assign o_de          = r_de;
  assign o_r           = r_rgb.r;
  assign o_g           = r_rgb.g;
  assign o_b           = r_rgb.b;
  assign o_frame_start = r_frame_start;
  assign o_line_req    = r_line_req;
  assign o_vblank      = r_vblank;
  assign o_underflow   = r_underflow;

endmodule

// File: tb/tb_mtl_lcd_tx.sv
// Self-checking bench for mtl_lcd_tx on a scaled-down raster, with a per-cycle output scoreboard.
module tb_mtl_lcd_tx;

  localparam int HT = 40, HS = 4, HAS = 6, HA = 24;
  localparam int VT = 20, VS = 2, VAS = 4, VA = 12;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  logic hsd, vsd, de, fs, lr, vb, uf;
  logic [7:0] r, g, b;

  mtl_lcd_tx_if fifo ();

  mtl_lcd_tx #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_ACT_START(HAS), .H_ACT(HA),
    .V_TOTAL(VT), .V_SYNC(VS), .V_ACT_START(VAS), .V_ACT(VA)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .fifo(fifo),
    .o_hsd(hsd), .o_vsd(vsd), .o_de(de), .o_r(r), .o_g(g), .o_b(b),
    .o_frame_start(fs), .o_line_req(lr), .o_vblank(vb), .o_underflow(uf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        hsd;
    logic        vsd;
    logic        de;
    logic [23:0] rgb;
    logic        fs;
    logic        lr;
    logic        vb;
    logic        uf;
  } outs_t;

  outs_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference raster and FIFO source model
  int          hc = 0, vc = 0;
  logic        m_uf = 1'b0;
  logic [23:0] src_word = 24'h000001;
  logic        force_empty = 1'b0;

  // Capture monitor state
  int cap_h = 0, cap_v = 0, frames = 0, dut_pops = 0, uf_pix = 0;
  bit cap_ok = 0, seen_de = 0, seen_lr = 0, prev_vb = 1;
  int a_hsd = 0, a_vsd = 0, a_de = 0, a_pop = 0, a_lr = 0, a_fs = 0;
  int d_hsd = 0, d_vsd = 0, d_de = 0, d_pop = 0, d_lr = 0, d_fs = 0;
  int fd_h = 0, fd_v = 0, ld_h = 0, ld_v = 0, flr_h = 0, flr_v = 0;
  int vbf_h = 0, vbf_v = 0, vbr_h = 0, vbr_v = 0;
  logic [23:0] base = '0;
  logic [23:0] img [VA][HA];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_act(input int h, input int v);
    return (h >= HAS) && (h < HAS + HA) && (v >= VAS) && (v < VAS + VA);
  endfunction

  function automatic logic [31:0] pos(input int v, input int h);
    return {16'(v), 16'(h)};
  endfunction

  task automatic monitor(input outs_t o);
    if (o.fs) begin
      d_hsd = a_hsd; d_vsd = a_vsd; d_de = a_de; d_pop = a_pop; d_lr = a_lr; d_fs = a_fs;
      a_hsd = 0; a_vsd = 0; a_de = 0; a_pop = 0; a_lr = 0; a_fs = 0;
      frames++;
      cap_h = 0; cap_v = 0; cap_ok = 1; seen_de = 0; seen_lr = 0;
    end else if (cap_ok) begin
      cap_h++;
      if (cap_h == HT) begin cap_h = 0; cap_v++; end
    end
    if (!o.hsd) a_hsd++;
    if (!o.vsd) a_vsd++;
    if (o.fs) a_fs++;
    if (o.lr) begin
      a_lr++;
      if (!seen_lr) begin flr_h = cap_h; flr_v = cap_v; seen_lr = 1; end
    end
    if (o.de) begin
      a_de++;
      if (o.rgb == 24'hFF00FF) uf_pix++;
      if (cap_ok) begin
        if (!seen_de) begin fd_h = cap_h; fd_v = cap_v; base = o.rgb; seen_de = 1; end
        ld_h = cap_h; ld_v = cap_v;
        if (cap_v >= VAS && cap_v < VAS + VA && cap_h >= HAS && cap_h < HAS + HA)
          img[cap_v - VAS][cap_h - HAS] = o.rgb;
      end
    end
    if (prev_vb && !o.vb) begin vbf_h = cap_h; vbf_v = cap_v; end
    if (!prev_vb && o.vb) begin vbr_h = cap_h; vbr_v = cap_v; end
    prev_vb = o.vb;
  endtask

  // One clock: drive FIFO, check the pop, push expected pins, advance, compare.
  task automatic step();
    outs_t e, o;
    logic  exp_pop;
    bit    act;
    fifo.i_pix_empty = force_empty;
    fifo.i_pix_data  = force_empty ? 24'hxxxxxx : src_word;
    #1;
    act     = m_act(hc, vc);
    exp_pop = en && act && !force_empty;
    check("pop", 32'(fifo.o_pix_rd), 32'(exp_pop));
    if (fifo.o_pix_rd === 1'b1) begin dut_pops++; a_pop++; end
    e = '0; e.hsd = 1'b1; e.vsd = 1'b1; e.vb = 1'b1;
    if (rst) m_uf = 1'b0;
    else if (en) begin
      e.hsd = !(hc < HS);
      e.vsd = !(vc < VS);
      e.de  = act;
      e.rgb = !act ? 24'h0 : (force_empty ? 24'hFF00FF : src_word);
      e.fs  = (hc == 0) && (vc == 0);
      e.lr  = (hc == 0) && (vc >= VAS - 1) && (vc <= VAS + VA - 2);
      e.vb  = !((vc >= VAS) && (vc < VAS + VA));
      if (act && force_empty) m_uf = 1'b1;
    end
    e.uf = m_uf;
    exp_q.push_back(e);
    if (exp_pop) src_word++;
    if (rst || !en) begin hc = 0; vc = 0; end
    else if (hc == HT - 1) begin hc = 0; vc = (vc == VT - 1) ? 0 : vc + 1; end
    else hc++;
    @(posedge clk);
    #1;
    o = {hsd, vsd, de, r, g, b, fs, lr, vb, uf};
    e = exp_q.pop_front();
    check("outs", 32'(o), 32'(e));
    monitor(o);
  endtask

  task automatic wait_pos(input int h, input int v, input string tag);
    int n = 0;
    while (!(hc == h && vc == v) && n < 2 * FRAME) begin step(); n++; end
    if (n >= 2 * FRAME) begin
      n_checks++; n_fail++;
      $display("FAIL %s: raster position (%0d,%0d) not reached within %0d cycles", tag, h, v, n);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int errs, f0, w0, p0;
    fifo.i_pix_empty = 1'b0;
    fifo.i_pix_data  = '0;
    for (int y = 0; y < VA; y++) for (int x = 0; x < HA; x++) img[y][x] = '0;

    // Reset held with i_en=1: reset must win
    repeat (2) @(posedge clk);
    #1;
    repeat (3) step();
    check("reset", 32'({hsd, vsd, de, r, g, b, fs, lr, vb, uf}), 32'({3'b110, 24'h0, 4'b0010}));

    // Free-running, FIFO never empty
    rst = 1'b0;
    step();
    check("rst_rel_fs", 32'(fs), 32'd1);
    f0 = frames;
    for (int i = 0; i < FRAME + 5 && frames < f0 + 1; i++) step();
    check("frame_seen", 32'(frames), 32'(f0 + 1));
    check("hsd_low", 32'(d_hsd), 32'(HS * VT));
    check("vsd_low", 32'(d_vsd), 32'(VS * HT));
    check("de_cnt", 32'(d_de), 32'(HA * VA));
    check("pop_cnt", 32'(d_pop), 32'(HA * VA));
    check("lr_cnt", 32'(d_lr), 32'(VA));
    check("fs_cnt", 32'(d_fs), 32'd1);
    check("first_de", pos(fd_v, fd_h), pos(VAS, HAS));
    check("last_de", pos(ld_v, ld_h), pos(VAS + VA - 1, HAS + HA - 1));
    check("first_lr", pos(flr_v, flr_h), pos(VAS - 1, 0));
    check("vb_fall", pos(vbf_v, vbf_h), pos(VAS, 0));
    check("vb_rise", pos(vbr_v, vbr_h), pos(VAS + VA, 0));
    errs = 0;
    for (int y = 0; y < VA; y++)
      for (int x = 0; x < HA; x++)
        if (img[y][x] !== base + 24'(y * HA + x)) errs++;
    check("image", 32'(errs), 32'd0);
    check("no_uf", 32'(uf), 32'd0);

    // FIFO empty for 5 active pixels mid-line
    wait_pos(HAS + 4, VAS + 5, "wait_uf");
    w0 = int'(src_word);
    p0 = dut_pops;
    uf_pix = 0;
    force_empty = 1'b1;
    repeat (5) step();
    force_empty = 1'b0;
    check("uf_pops", 32'(dut_pops - p0), 32'd0);
    check("uf_pix", 32'(uf_pix), 32'd5);
    check("uf_set", 32'(uf), 32'd1);
    step();
    check("uf_resume", 32'({r, g, b}), 32'(w0));
    repeat (20) step();
    check("uf_sticky", 32'(uf), 32'd1);

    // i_en low for 10 cycles mid-frame
    wait_pos(HAS + 3, VAS + 2, "wait_en");
    en = 1'b0;
    p0 = dut_pops;
    repeat (10) step();
    check("en_idle", 32'({hsd, vsd, de, r, g, b, fs, lr, vb}), 32'({3'b110, 24'h0, 3'b001}));
    check("en_pops", 32'(dut_pops - p0), 32'd0);
    check("en_uf_hold", 32'(uf), 32'd1);
    en = 1'b1;
    step();
    check("en_fs", 32'(fs), 32'd1);

    // Reset mid-frame, inside the active window
    wait_pos(HAS + 10, VAS + 7, "wait_rst");
    rst = 1'b1;
    step();
    check("rst_uf", 32'(uf), 32'd0);
    check("rst_idle", 32'({hsd, vsd, de, r, g, b, fs, lr, vb}), 32'({3'b110, 24'h0, 3'b001}));
    rst = 1'b0;
    step();
    check("rst_fs", 32'(fs), 32'd1);
    repeat (HT * (VAS + 2)) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mtl_lcd_tx.md
Name: mtl_lcd_tx

Overview:
- Video transmitter for the MTL multi-touch LCD panel. It generates the panel's 800x480 timing and drives 24-bit RGB from a show-ahead pixel FIFO.
- The FIFO is filled upstream by the NES console's scaler.
- Sits between the console's LCD clock domain and the MTL_* board pins, and is the sending end of the DCLK/HSD/VSD/RGB link.

Parameters:
- H_TOTAL, 1056: pixel clocks per line.
- H_SYNC, 30: HSD low width, in clocks, from hcnt 0.
- H_ACT_START, 50: first active hcnt.
- H_ACT, 800: active pixels per line.
- V_TOTAL, 525: lines per frame.
- V_SYNC, 13: VSD low width, in lines, from vcnt 0.
- V_ACT_START, 23: first active line.
- V_ACT, 480: active lines per frame.
- UNDERFLOW_RGB, 24'hFF00FF: colour driven on an active pixel when the FIFO is empty.

Ports:
- i_clk, input, 1: LCD pixel clock, also forwarded as DCLK.
- i_rst, input, 1: synchronous, active-high reset.
- i_en, input, 1: timing enable; 0 holds the block idle.
- i_pix_data, input, 24: {R,G,B} at the FIFO head (show-ahead).
- i_pix_empty, input, 1: FIFO empty.
- o_pix_rd, output, 1: FIFO pop, combinational.
- o_hsd, output, 1: horizontal sync, active low.
- o_vsd, output, 1: vertical sync, active low.
- o_de, output, 1: data-enable, high on active pixels.
- o_r, output, 8: red.
- o_g, output, 8: green.
- o_b, output, 8: blue.
- o_frame_start, output, 1: one-cycle pulse at hcnt=0, vcnt=0.
- o_line_req, output, 1: one-cycle pulse at hcnt=0 of the line preceding each active line (vcnt V_ACT_START-1 .. V_ACT_START+V_ACT-2).
- o_vblank, output, 1: high while vcnt is outside the active line range.
- o_underflow, output, 1: sticky; set on an active pixel with FIFO empty; cleared only by i_rst.

Behaviour:
- Clock/reset: one clock (i_clk). Reset is synchronous and active-high (i_rst).
- Reset values: hcnt=0, vcnt=0, o_hsd=1, o_vsd=1, o_de=0, RGB=0, o_frame_start=0, o_line_req=0, o_vblank=1, o_underflow=0.
- Counters:
  - hcnt is 11 bits and counts 0..H_TOTAL-1, then wraps to 0.
  - vcnt is 10 bits and increments when hcnt wraps; it counts 0..V_TOTAL-1, then wraps to 0.
  - Both counters advance only while i_en=1.
- i_en=0:
  - Counters are forced to 0 on the next edge.
  - o_pix_rd=0.
  - All outputs take their reset values, except o_underflow, which holds.
  - On re-enable, the frame restarts at hcnt=0, vcnt=0.
- Active region: act = (H_ACT_START <= hcnt < H_ACT_START+H_ACT) and (V_ACT_START <= vcnt < V_ACT_START+V_ACT).
- Pop: o_pix_rd = i_en & act & ~i_pix_empty, combinational from the counters. There is exactly one pop per active pixel when data is available.
- Output latency: every registered output is 1 cycle behind its counter value. For the counter value at edge n:
  - o_hsd = ~(hcnt < H_SYNC)
  - o_vsd = ~(vcnt < V_SYNC)
  - o_de = act
  - RGB = i_pix_data if act and FIFO not empty; UNDERFLOW_RGB if act and FIFO empty; 0 if not act.
- Alignment: the first active pixel of a frame appears on the pins in the cycle after hcnt=50, vcnt=23, together with o_de=1.
- Underflow: an empty FIFO during act produces no pop and outputs UNDERFLOW_RGB; the pixel slot is consumed. The timing never stalls.
- Width rule: RGB outputs are never X. If i_pix_data is X while the FIFO is empty, it must not propagate to the outputs.
- Pulses: o_frame_start and o_line_req are registered with the same 1-cycle latency.
- Reset mid-frame: the next cycle shows reset values, and the counters restart from 0.

Decomposition:
- Package mtl_lcd_pkg holds:
  - timing defaults as localparams;
  - typedef rgb24_t (packed struct r, g, b);
  - a function for the active-window compare.
- One sub-module, mtl_timing_cnt: the hcnt/vcnt counters, the i_en force-to-zero logic, and the decoded flags act, hsync, vsync, frame_start and line_req.
- The top level adds the FIFO pop, the RGB mux, the output registers and the sticky underflow.

Test Plan:
- Free-running, FIFO always non-empty with an incrementing pattern:
  - o_hsd low exactly 30 of every 1056 clocks;
  - o_vsd low 13 lines of every 525;
  - o_de high 800x480 = 384000 cycles per frame;
  - o_pix_rd count per frame = 384000.
- Alignment with a pattern source:
  - the first o_de=1 occurs 1 cycle after hcnt=50, vcnt=23, with RGB = first popped word;
  - the last o_de=1 occurs 1 cycle after hcnt=849, vcnt=502;
  - a capture monitor using a 1056x525 counter recovers an 800x480 image identical to the source.
- FIFO empty for 5 cycles mid-line 100: no pops; RGB = FF00FF for those 5 pixels; o_underflow=1 and stays 1; the following pixels resume from the FIFO head.
- Toggling i_en: i_en=0 for 10 cycles mid-frame → outputs idle (hsd=1, vsd=1, de=0, rgb=0, no pops); after re-enable, o_frame_start pulses 1 cycle later.
- Reset:
  - i_rst asserted at hcnt=600, vcnt=200 → next cycle all outputs at reset values;
  - after release, frame_start appears after 1 cycle;
  - o_underflow is cleared.
- Pulse counts per frame: o_line_req 480 pulses, the first at vcnt=22, hcnt=0; o_frame_start 1 pulse; o_vblank falls at the vcnt=23 output edge and rises at the vcnt=503 output edge.
